// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative RV32M multiply/divide engine that borrows the shared
// EX-stage ALU adder. It runs one shift-add or restoring-divide step per granted
// cycle and stalls the pipeline with BUSY until a one-cycle DONE pulse.
//
// Handshake: ALU_REQ is high for the whole of ITER. A step is committed only on
// a rising CLK edge where ALU_REQ && ALU_GNT are both high. ALU_SUM is consumed
// in that same cycle. While ALU_GNT is low, all registers and the counter hold.
module mdu_sequencer (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] RS1,
  input  logic [31:0] RS2,
  input  logic        FLUSH,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RESULT,
  output logic        ALU_REQ,
  input  logic        ALU_GNT,
  output logic [31:0] ALU_A,
  output logic [31:0] ALU_B,
  output logic [3:0]  ALU_CTRL,
  input  logic [31:0] ALU_SUM,
  output logic [2:0]  DBG_STATE
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_f3;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic [31:0] r_a;       // multiplicand or divisor magnitude
  logic [31:0] r_hi;      // HI (multiply) or partial remainder R (divide)
  logic [31:0] r_lo;      // LO (multiply) or quotient Q (divide)
  logic [4:0]  r_cnt;
  logic        r_neg_q;   // product / quotient must be negated
  logic        r_neg_r;   // remainder must be negated
  logic [31:0] r_result;

  logic        w_is_div;
  logic        w_sgn1;
  logic        w_sgn2;
  logic [31:0] w_mag1;
  logic [31:0] w_mag2;
  logic        w_div_zero;
  logic        w_ovf;
  logic        w_special;
  logic [31:0] w_special_res;
  logic [31:0] w_div_a;
  logic        w_carry;
  logic        w_borrow;
  logic        w_ge;
  logic        w_step;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_fix_res;

  // Operand signedness and magnitudes, evaluated in PREP from latched operands.
  // MULH and DIV/REM are signed on both sides, MULHSU only on RS1.
  assign w_is_div = r_f3[2];
  assign w_sgn1   = (w_is_div ? ~r_f3[0] : (r_f3 == 3'b001 || r_f3 == 3'b010)) & r_rs1[31];
  assign w_sgn2   = (w_is_div ? ~r_f3[0] : (r_f3 == 3'b001)) & r_rs2[31];
  assign w_mag1   = w_sgn1 ? (32'd0 - r_rs1) : r_rs1;
  assign w_mag2   = w_sgn2 ? (32'd0 - r_rs2) : r_rs2;

  // Divide corner cases resolve directly in PREP without iterating.
  assign w_div_zero    = w_is_div & (r_rs2 == 32'd0);
  assign w_ovf         = w_is_div & ~r_f3[0] & (r_rs1 == 32'h8000_0000) & (r_rs2 == 32'hFFFF_FFFF);
  assign w_special     = w_div_zero | w_ovf;
  assign w_special_res = r_f3[1] ? (w_div_zero ? r_rs1 : 32'd0)
                                 : (w_div_zero ? 32'hFFFF_FFFF : 32'h8000_0000);

  // Shared-ALU operand drive; everything is zero outside ITER.
  assign w_div_a  = {r_hi[30:0], r_lo[31]};
  assign ALU_REQ  = (r_state == S_ITER);
  assign ALU_A    = !ALU_REQ ? 32'd0 : (w_is_div ? w_div_a : r_hi);
  assign ALU_B    = !ALU_REQ ? 32'd0 : (w_is_div ? r_a : (r_lo[0] ? r_a : 32'd0));
  assign ALU_CTRL = (ALU_REQ && w_is_div) ? 4'b0001 : 4'b0000;

  // Carry/borrow out of bit 31 rebuilt from the ALU's MSB inputs and sum.
  assign w_carry  = (ALU_A[31] & ALU_B[31]) | ((ALU_A[31] | ALU_B[31]) & ~ALU_SUM[31]);
  assign w_borrow = (~ALU_A[31] & ALU_B[31]) | ((~ALU_A[31] | ALU_B[31]) & ALU_SUM[31]);
  assign w_ge     = r_hi[31] | ~w_borrow;
  assign w_step   = ALU_REQ & ALU_GNT;

  // Sign fix-up and final result select.
  assign w_prod    = r_neg_q ? (64'd0 - {r_hi, r_lo}) : {r_hi, r_lo};
  assign w_quo     = r_neg_q ? (32'd0 - r_lo) : r_lo;
  assign w_rem     = r_neg_r ? (32'd0 - r_hi) : r_hi;
  assign w_fix_res = w_is_div ? (r_f3[1] ? w_rem : w_quo)
                              : ((r_f3[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32]);

  assign BUSY      = (r_state == S_PREP) || (r_state == S_ITER) || (r_state == S_FIX);
  assign DONE      = (r_state == S_DONE);
  assign RESULT    = r_result;
  assign DBG_STATE = r_state;

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; FLUSH overrides every transition.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (START) w_next = S_PREP;
      S_PREP: w_next = w_special ? S_DONE : S_ITER;
      S_ITER: if (w_step && r_cnt == 5'd31) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (FLUSH) w_next = S_IDLE;
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_f3     <= 3'd0;
      r_rs1    <= 32'd0;
      r_rs2    <= 32'd0;
      r_a      <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_cnt    <= 5'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START && !FLUSH) begin
            r_f3  <= FUNCT3;
            r_rs1 <= RS1;
            r_rs2 <= RS2;
          end
        end
        S_PREP: begin
          r_lo    <= w_mag1;
          r_a     <= w_mag2;
          r_hi    <= 32'd0;
          r_cnt   <= 5'd0;
          r_neg_q <= w_sgn1 ^ w_sgn2;
          r_neg_r <= w_sgn1;
          if (w_special && !FLUSH) r_result <= w_special_res;
        end
        S_ITER: begin
          if (w_step) begin
            r_cnt <= r_cnt + 5'd1;
            if (w_is_div) begin
              r_hi <= w_ge ? ALU_SUM : w_div_a;
              r_lo <= {r_lo[30:0], w_ge};
            end else begin
              r_hi <= {w_carry, ALU_SUM[31:1]};
              r_lo <= {ALU_SUM[0], r_lo[31:1]};
            end
          end
        end
        S_FIX: begin
          if (!FLUSH) r_result <= w_fix_res;
        end
        default: ;
      endcase
    end
  end

endmodule
